intt_scale_out: RTL and testbench

- Downstream stage of the INTT processing element.
- Consumes the stream of final-stage PE results and multiplies each coefficient by n^-1 mod Q, completing the inverse transform.
- Emits normalised coefficients with a coefficient index and a last-of-frame flag.
- Two-stage pipeline with valid/ready handshakes on both sides, so the PE array can be stalled by the result buffer.

---
 rtl/intt_scale_out_pkg.sv | 20 ++
 rtl/intt_scale_skid.sv | 60 ++++++
 rtl/modred.sv | 30 +++
 rtl/mult.sv | 12 +
 rtl/intt_scale_out.sv | 89 ++++++++
 tb/tb_intt_scale_out.sv | 232 +++++++++++++++++++++++
 6 files changed

// File: rtl/intt_scale_out_pkg.sv
// Shared constants and helpers for the INTT output scaling stage.
// Default coefficient width, modulus, transform size and n^-1 mod Q.
package intt_scale_out_pkg;

  localparam int COEF_N    = 9;
  localparam int COEF_Q    = 257;
  localparam int COEF_LOGN = 8;
  localparam int COEF_NINV = 256;
  localparam int FRAME_LEN = 1 << COEF_LOGN;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/intt_scale_skid.sv
// Two-entry valid/ready pipeline: payload registers and valid flags for
// S1 and S2; the S1->S2 payload transform is supplied from outside.
module intt_scale_skid
  import intt_scale_out_pkg::*;
#(
  parameter int P1_W = 8,
  parameter int P2_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [P1_W-1:0] in_pay,
  output logic [P1_W-1:0] s1_pay,
  input  logic [P2_W-1:0] s2_in,
  output logic [P2_W-1:0] out_pay,
  output logic            out_valid,
  input  logic            out_ready
);

  logic            s1_valid;
  logic            s2_valid;
  logic            s1_load;
  logic            s2_load;
  logic [P1_W-1:0] pay_p1;
  logic [P2_W-1:0] pay_p2;

  // Ready propagates combinationally back from the output so a full
  // pipeline still accepts one word per cycle while draining.
  always_comb begin
    s2_load = !s2_valid || out_ready;
    s1_load = !s1_valid || s2_load;
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid;
  assign s1_pay    = pay_p1;
  assign out_pay   = pay_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      pay_p1   <= '0;
      pay_p2   <= '0;
    end else begin
      // S1 boundary
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) pay_p1 <= in_pay;
      end
      // S2 boundary
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) pay_p2 <= s2_in;
      end
    end
  end

endmodule

// File: rtl/modred.sv
// Combinational reduction of a 2*LOGQ-bit product modulo Q.
// Restoring subtraction of Q<<k; exact for any product below 2^(2*LOGQ).
module modred
  import intt_scale_out_pkg::*;
#(
  parameter int LOGQ = 9,
  parameter int Q    = 257
) (
  input  logic [2*LOGQ-1:0] x,
  output logic [LOGQ-1:0]   y
);

  // Q << (K+1) >= 2^(2*LOGQ), so K+1 conditional subtractions leave r < Q.
  localparam int K  = 2 * LOGQ - clog2(Q + 1);
  localparam int WW = 2 * LOGQ + 1;

  function automatic logic [LOGQ-1:0] reduce(input logic [2*LOGQ-1:0] v);
    logic [WW-1:0] r;
    logic [WW-1:0] qs;
    r = {1'b0, v};
    for (int k = K; k >= 0; k--) begin
      qs = WW'(Q) << k;
      if (r >= qs) r = r - qs;
    end
    return r[LOGQ-1:0];
  endfunction

  assign y = reduce(x);

endmodule

// File: rtl/mult.sv
// Unsigned W x W -> 2W multiplier shared by the NTT/INTT datapaths.
module mult #(
  parameter int W = 9
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/intt_scale_out.sv
// INTT output stage: multiplies each coefficient by n^-1 mod Q and tags it
// with its frame index and a last-of-frame flag.
module intt_scale_out
  import intt_scale_out_pkg::*;
#(
  parameter int N    = COEF_N,
  parameter int Q    = COEF_Q,
  parameter int LOGN = COEF_LOGN,
  parameter int NINV = COEF_NINV
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N-1:0]    out_data,
  output logic [LOGN-1:0] out_idx,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            err_range
);

  localparam int P1_W = 2 * N + LOGN + 1;
  localparam int P2_W = N + LOGN + 1;

  localparam logic [N-1:0]    NINV_W   = N'(NINV);
  localparam logic [N-1:0]    Q_W      = N'(Q);
  localparam logic [LOGN-1:0] IDX_LAST = '1;

  logic [2*N-1:0]  prod;
  logic [LOGN-1:0] idx_cnt;
  logic            accept;

  logic [P1_W-1:0] pay_in;
  logic [P1_W-1:0] pay_p1;
  logic [2*N-1:0]  prod_p1;
  logic [LOGN-1:0] idx_p1;
  logic            last_p1;
  logic [N-1:0]    red_p1;
  logic [P2_W-1:0] pay_s2;
  logic [P2_W-1:0] pay_p2;

  assign accept = in_valid && in_ready;

  mult #(.W(N)) u_mult (
    .a (in_data),
    .b (NINV_W),
    .p (prod)
  );

  assign pay_in = {prod, idx_cnt, (idx_cnt == IDX_LAST)};

  intt_scale_skid #(.P1_W(P1_W), .P2_W(P2_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pay    (pay_in),
    .s1_pay    (pay_p1),
    .s2_in     (pay_s2),
    .out_pay   (pay_p2),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign {prod_p1, idx_p1, last_p1} = pay_p1;

  // S1 -> S2 boundary: reduce the registered product
  modred #(.LOGQ(N), .Q(Q)) u_modred (
    .x (prod_p1),
    .y (red_p1)
  );

  assign pay_s2                        = {red_p1, idx_p1, last_p1};
  assign {out_data, out_idx, out_last} = pay_p2;

  // Index wraps naturally at 2^LOGN, so frames follow back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_cnt   <= '0;
      err_range <= 1'b0;
    end else if (accept) begin
      idx_cnt <= idx_cnt + 1'b1;
      if (in_data >= Q_W) err_range <= 1'b1;
    end
  end

endmodule

// File: tb/tb_intt_scale_out.sv
// Scoreboard bench for intt_scale_out: a driver queues expected results
// from an arithmetic model, a monitor checks every output transfer.
module tb_intt_scale_out;

  localparam int N    = 9;
  localparam int Q    = 257;
  localparam int LOGN = 8;
  localparam int NINV = 256;
  localparam int FLEN = 1 << LOGN;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N-1:0]    out_data;
  logic [LOGN-1:0] out_idx;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            err_range;

  intt_scale_out dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int idx;
    int last;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;
  bit   lat_chk  = 1'b0;
  int   m_idx    = 0;
  bit   m_err    = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int model(input int x);
    return (x * NINV) % Q;
  endfunction

  // out_ready: 0 = always 1, 1 = random, 2 = held low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom % 2);
      default: out_ready = 1'b0;
    endcase
  end

  int              inflight = 0;
  bit              stall_prev = 1'b0;
  logic [N-1:0]    sd;
  logic [LOGN-1:0] si;
  logic            sl;
  exp_t            e;

  always @(negedge clk) begin
    if (rst) begin
      inflight   = 0;
      stall_prev = 1'b0;
    end else begin
      check("in_ready", int'(in_ready), int'(!(inflight == 2 && !out_ready)));
      if (stall_prev)
        check("stall_hold", int'({out_valid, out_data, out_idx, out_last}),
              int'({1'b1, sd, si, sl}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_out: got idx %0d data %0d with nothing queued",
                   out_idx, out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", int'(out_data), e.data);
          check("out_idx", int'(out_idx), e.idx);
          check("out_last", int'(out_last), e.last);
          if (lat_chk) check("latency", cyc - e.cyc, 2);
        end
      end
      stall_prev = out_valid && !out_ready;
      sd = out_data;
      si = out_idx;
      sl = out_last;
      inflight = inflight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int x);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = x[N-1:0];
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{model(x), m_idx, int'(m_idx == FLEN - 1), cyc});
        m_idx = (m_idx + 1) % FLEN;
        if (x >= Q) m_err = 1'b1;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout: in_ready stayed 0 for value %0d", x);
    end else begin
      check("err_range", int'(err_range), int'(m_err));
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && sb.size() > 0; t++) idle(1);
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d outputs outstanding expected 0", sb.size());
    end
    idle(2);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_fields", int'({out_data, out_idx, out_last}), 0);
    check("rst_err_range", int'(err_range), 0);
    sb.delete();
    m_idx = 0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // latency and first values
    lat_chk = 1'b1;
    send(1);
    idle(4);
    send(2);
    send(0);
    send(256);
    idle(4);
    lat_chk = 1'b0;

    // full frame plus wrap
    do_reset();
    for (int i = 0; i < FLEN + 3; i++) send(i % Q);
    drain();

    // random valid / ready
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom % 2) idle(1);
      send(int'($urandom_range(0, Q - 1)));
    end
    drain();

    // out-of-range input, then legal ones
    rdy_mode = 0;
    idle(2);
    send(300);
    send(5);
    send(7);
    send(Q - 1);
    drain();

    // reset with two coefficients in flight at idx 5
    while (m_idx != 5) send(int'($urandom_range(0, Q - 1)));
    drain();
    rdy_mode = 2;
    idle(2);
    send(10);
    send(11);
    idle(1);
    do_reset();
    rdy_mode = 0;
    idle(2);
    send(9);
    send(3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1);
  end

endmodule
